// File: rtl/crc16_frame_ctrl.sv
// Frame sequencer for an 8-bit-parallel CRC-16 engine: it forwards the payload,
// clears the engine, waits out the engine latency and appends CRC (MSB byte first).
module crc16_frame_ctrl #(
   parameter int MAX_LEN = 256,
   parameter int LEN_W   = 9,
   parameter int CLR_CYC = 2,
   parameter int ENG_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [7:0]       m_data,
   output logic             m_last,
   output logic             eng_rst_n,
   output logic [7:0]       eng_data,
   output logic             eng_valid,
   input  logic [15:0]      eng_crc,
   output logic             busy,
   output logic [LEN_W-1:0] frame_len,
   output logic             len_err,
   output logic             frame_done
);

   // state  | meaning
   // IDLE   | no frame; first s_valid starts a frame
   // CLEAR  | engine held in clear for CLR_CYC cycles
   // DATA   | payload passed through to downstream and engine
   // DRAIN  | frame over length; remaining bytes accepted and dropped
   // WAIT   | ENG_LAT cycles for engine result to settle
   // CRC_HI | emit crc_q[15:8]
   // CRC_LO | emit crc_q[7:0] with m_last
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      DATA   = 3'd2,
      DRAIN  = 3'd3,
      WAIT   = 3'd4,
      CRC_HI = 3'd5,
      CRC_LO = 3'd6
   } state_t;

   localparam int TMR_MAX = (CLR_CYC > ENG_LAT) ? CLR_CYC : ENG_LAT;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYC - 1);
   localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(ENG_LAT - 1);
   localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

   state_t           state;
   state_t           state_nx;
   logic [TMR_W-1:0] tmr;
   logic             tmr_tc;
   logic [LEN_W-1:0] count;
   logic [15:0]      crc_q;
   logic             u;
   logic             d;

   assign tmr_tc   = (tmr == '0);
   assign u        = s_valid & s_ready;
   assign d        = m_valid & m_ready;
   assign eng_data = s_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (s_valid) state_nx = CLEAR;
         CLEAR:  if (tmr_tc) state_nx = DATA;
         DATA: begin
            if (u) begin
               if (s_last) begin
                  state_nx = WAIT;
               end else if (count == LAST_IDX) begin
                  state_nx = DRAIN;
               end
            end
         end
         DRAIN:  if (u && s_last) state_nx = WAIT;
         WAIT:   if (tmr_tc) state_nx = CRC_HI;
         CRC_HI: if (d) state_nx = CRC_LO;
         CRC_LO: if (d) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Engine clear is forced during reset so the engine never sees a stale frame.
   always_comb begin
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_data     = 8'h00;
      m_last     = 1'b0;
      eng_valid  = 1'b0;
      eng_rst_n  = ~rst;
      busy       = (state != IDLE);
      frame_done = 1'b0;
      case (state)
         CLEAR: eng_rst_n = 1'b0;
         DATA: begin
            s_ready   = m_ready;
            m_valid   = s_valid;
            m_data    = s_data;
            eng_valid = s_valid & m_ready;
         end
         DRAIN: s_ready = 1'b1;
         CRC_HI: begin
            m_valid = 1'b1;
            m_data  = crc_q[15:8];
         end
         CRC_LO: begin
            m_valid    = 1'b1;
            m_data     = crc_q[7:0];
            m_last     = 1'b1;
            frame_done = m_ready;
         end
         default: ;
      endcase
   end

   // Shared down-counter times both the clear window and the engine latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr       <= '0;
         count     <= '0;
         crc_q     <= 16'h0000;
         frame_len <= '0;
         len_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid) begin
                  tmr     <= CLR_LOAD;
                  count   <= '0;
                  len_err <= 1'b0;
               end
            end
            CLEAR: if (!tmr_tc) tmr <= tmr - TMR_W'(1);
            DATA: begin
               if (u) begin
                  count <= count + LEN_W'(1);
                  if (s_last) begin
                     tmr <= LAT_LOAD;
                  end else if (count == LAST_IDX) begin
                     len_err <= 1'b1;
                  end
               end
            end
            DRAIN: if (u && s_last) tmr <= LAT_LOAD;
            WAIT: begin
               if (tmr_tc) begin
                  crc_q <= eng_crc;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            CRC_LO: if (d) frame_len <= count;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Bench for crc16_frame_ctrl: directed frame table with a constant-CRC engine stub,
// then random frames against a real CRC-16 stub checked by a frame-level model.
module tb_crc16_frame_ctrl;

   localparam int MAX_LEN = 4;
   localparam int LEN_W   = 3;
   localparam int CLR_CYC = 2;
   localparam int ENG_LAT = 2;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      int          n;
      logic [63:0] din;
      int          rdy;
      int          nout;
      logic [63:0] dout;
      int          len;
      bit          err;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [7:0]       s_data = 8'h00;
   logic             s_last = 1'b0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [7:0]       m_data;
   logic             m_last;
   logic             eng_rst_n;
   logic [7:0]       eng_data;
   logic             eng_valid;
   logic [15:0]      eng_crc;
   logic             busy;
   logic [LEN_W-1:0] frame_len;
   logic             len_err;
   logic             frame_done;

   always #5 clk = ~clk;

   crc16_frame_ctrl #(
      .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLR_CYC(CLR_CYC), .ENG_LAT(ENG_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .eng_rst_n(eng_rst_n), .eng_data(eng_data), .eng_valid(eng_valid), .eng_crc(eng_crc),
      .busy(busy), .frame_len(frame_len), .len_err(len_err), .frame_done(frame_done)
   );

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   function automatic logic [15:0] crc_of(input bq_t q);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (q[i]) c = crc16_byte(c, q[i]);
      return c;
   endfunction

   function automatic bq_t bytes_of(input logic [63:0] v, input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(v[63-8*i -: 8]);
      return q;
   endfunction

   // Engine stub: one accumulate stage plus one delay stage = ENG_LAT of 2.
   logic [15:0] eng_acc = 16'hFFFF;
   logic [15:0] eng_dly = 16'hFFFF;
   bit          crc_mode = 1'b0;
   always @(posedge clk) begin
      if (!eng_rst_n) eng_acc <= 16'hFFFF;
      else if (eng_valid) eng_acc <= crc16_byte(eng_acc, eng_data);
      eng_dly <= eng_acc;
   end
   assign eng_crc = crc_mode ? eng_dly : 16'hBEEF;

   int rdy_mode = 0;
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   logic [8:0] got_q[$];
   int         done_cnt = 0;
   int         done_bad = 0;
   int         hold_bad = 0;
   int         clr_run = 0;
   int         last_run = -1;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         clr_run    = 0;
         prev_stall = 1'b0;
      end else begin
         if (m_valid && m_ready) got_q.push_back({m_last, m_data});
         if (frame_done) begin
            done_cnt++;
            if (!(m_valid && m_ready && m_last)) done_bad++;
         end
         if (prev_stall && (!m_valid || m_data !== prev_data)) hold_bad++;
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         if (!eng_rst_n) begin
            clr_run++;
         end else if (clr_run != 0) begin
            last_run = clr_run;
            clr_run  = 0;
         end
      end
   end

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      nvec++;
      nmis++;
      $display("FAIL %s: no response within cycle bound", name);
   endtask

   task automatic send_frame(input bq_t d, input bit gaps, input bit with_last,
                             output int stall, output bit ok);
      int k;
      stall = 0;
      ok    = 1'b1;
      for (int i = 0; i < d.size(); i++) begin
         if (gaps) while ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         s_valid = 1'b1;
         s_data  = d[i];
         s_last  = with_last && (i == d.size() - 1);
         k = 0;
         @(negedge clk);
         while (!s_ready && ok) begin
            if (i == 0) stall++;
            k++;
            if (k > 200) begin
               fail_timeout("s_ready");
               ok = 1'b0;
            end else begin
               @(negedge clk);
            end
         end
         if (!ok) break;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      int k;
      ok = 1'b1;
      k  = 0;
      @(negedge clk);
      while (!frame_done && ok) begin
         k++;
         if (k > 300) begin
            fail_timeout("frame_done");
            ok = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_frame(input bq_t d, input bit gaps, input bq_t expq,
                            input int exp_len, input bit exp_err, input bit chk_stall);
      int         stall;
      bit         ok;
      logic [8:0] beat;
      got_q.delete();
      done_cnt = 0;
      done_bad = 0;
      hold_bad = 0;
      last_run = -1;
      send_frame(d, gaps, 1'b1, stall, ok);
      if (ok) wait_done(ok);
      if (!ok) return;
      chk("beat_count", got_q.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         beat = (i < got_q.size()) ? got_q[i] : 9'bx;
         chk($sformatf("m_data[%0d]", i), beat[7:0], expq[i]);
         chk($sformatf("m_last[%0d]", i), beat[8], i == expq.size() - 1);
      end
      chk("frame_len", frame_len, exp_len);
      chk("len_err", len_err, exp_err);
      chk("frame_done_pulses", done_cnt, 1);
      chk("frame_done_align", done_bad, 0);
      chk("m_data_hold", hold_bad, 0);
      chk("clear_cycles", last_run, CLR_CYC);
      if (chk_stall) chk("ready_gap", stall, 1 + CLR_CYC);
      chk("busy_after_frame", busy, 0);
   endtask

   vec_t tbl[7];

   initial begin
      int          stall;
      bit          ok;
      bq_t         d;
      bq_t         fwd;
      bq_t         expq;
      logic [15:0] c;
      int          n;

      tbl[0] = '{3, {8'h11, 8'h22, 8'h33, 40'h0}, 0, 5,
                 {8'h11, 8'h22, 8'h33, 8'hBE, 8'hEF, 24'h0}, 3, 1'b0};
      tbl[1] = '{4, {8'hA1, 8'hA2, 8'hA3, 8'hA4, 32'h0}, 0, 6,
                 {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hBE, 8'hEF, 16'h0}, 4, 1'b0};
      tbl[2] = '{7, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00}, 0, 6,
                 {8'h01, 8'h02, 8'h03, 8'h04, 8'hBE, 8'hEF, 16'h0}, 4, 1'b1};
      tbl[3] = '{2, {8'h5A, 8'hC3, 48'h0}, 1, 4,
                 {8'h5A, 8'hC3, 8'hBE, 8'hEF, 32'h0}, 2, 1'b0};
      tbl[4] = '{1, {8'h77, 56'h0}, 0, 3,
                 {8'h77, 8'hBE, 8'hEF, 40'h0}, 1, 1'b0};
      tbl[5] = '{2, {8'hC0, 8'hDE, 48'h0}, 0, 4,
                 {8'hC0, 8'hDE, 8'hBE, 8'hEF, 32'h0}, 2, 1'b0};
      tbl[6] = '{5, {8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 24'h0}, 2, 6,
                 {8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hBE, 8'hEF, 16'h0}, 4, 1'b1};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_eng_rst_n", eng_rst_n, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_eng_rst_n", eng_rst_n, 1);
      chk("idle_m_valid", m_valid, 0);
      chk("idle_frame_len", frame_len, 0);
      chk("idle_len_err", len_err, 0);
      @(posedge clk);
      #1;

      for (int t = 0; t < 7; t++) begin
         rdy_mode = tbl[t].rdy;
         run_frame(bytes_of(tbl[t].din, tbl[t].n), 1'b0,
                   bytes_of(tbl[t].dout, tbl[t].nout),
                   tbl[t].len, tbl[t].err, tbl[t].rdy == 0);
      end

      // Abandon a frame in DATA with a reset; nothing of it may survive.
      rdy_mode = 0;
      send_frame(bytes_of({8'h11, 8'h22, 48'h0}, 2), 1'b0, 1'b0, stall, ok);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_eng_rst_n", eng_rst_n, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_s_ready", s_ready, 0);
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_m_last", m_last, 0);
      chk("midrst_eng_valid", eng_valid, 0);
      chk("midrst_frame_done", frame_done, 0);
      chk("midrst_frame_len", frame_len, 0);
      chk("midrst_len_err", len_err, 0);
      chk("midrst_eng_rst_n_hi", eng_rst_n, 1);
      @(posedge clk);
      #1;
      run_frame(bytes_of(tbl[0].din, tbl[0].n), 1'b0,
                bytes_of(tbl[0].dout, tbl[0].nout), 3, 1'b0, 1'b1);

      crc_mode = 1'b1;
      for (int f = 0; f < 40; f++) begin
         n = $urandom_range(1, 7);
         d.delete();
         for (int i = 0; i < n; i++) d.push_back(8'($urandom));
         fwd.delete();
         for (int i = 0; i < n && i < MAX_LEN; i++) fwd.push_back(d[i]);
         c    = crc_of(fwd);
         expq = fwd;
         expq.push_back(c[15:8]);
         expq.push_back(c[7:0]);
         rdy_mode = $urandom_range(0, 2);
         run_frame(d, 1'($urandom_range(0, 1)), expq, fwd.size(), n > MAX_LEN, rdy_mode == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
